mult_arbiter_tainttrack: RTL and testbench

MULT_ARBITER_TAINTTRACK -- requirements
Module: mult_arbiter_tainttrack

---
 rtl/mult_arbiter_tainttrack.sv | 175 +++++++++++++++++
 tb/tb_mult_arbiter_tainttrack.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter_tainttrack.sv
// Round-robin front end sharing one multiplier between two requesters, with taint carried on every path.
// Grant 1 cycle after an IDLE request, done 1 cycle after the multiplier's done rising edge; requests outside IDLE wait.
module mult_arbiter_tainttrack #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic                 req0_t,
    input  logic                 req1,
    input  logic                 req1_t,
    input  logic [WIDTH-1:0]     a0,
    input  logic [WIDTH-1:0]     a0_t,
    input  logic [WIDTH-1:0]     b0,
    input  logic [WIDTH-1:0]     b0_t,
    input  logic [WIDTH-1:0]     a1,
    input  logic [WIDTH-1:0]     a1_t,
    input  logic [WIDTH-1:0]     b1,
    input  logic [WIDTH-1:0]     b1_t,
    output logic                 gnt0,
    output logic                 gnt0_t,
    output logic                 gnt1,
    output logic                 gnt1_t,
    output logic                 done0,
    output logic                 done0_t,
    output logic                 done1,
    output logic                 done1_t,
    output logic [2*WIDTH-1:0]   result,
    output logic [2*WIDTH-1:0]   result_t,
    output logic                 mul_start,
    output logic                 mul_start_t,
    output logic [WIDTH-1:0]     mul_multiplier,
    output logic [WIDTH-1:0]     mul_multiplier_t,
    output logic [WIDTH-1:0]     mul_multiplicand,
    output logic [WIDTH-1:0]     mul_multiplicand_t,
    input  logic [2*WIDTH-1:0]   mul_product,
    input  logic [2*WIDTH-1:0]   mul_product_t,
    input  logic                 mul_done,
    input  logic                 mul_done_t
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_RESP} state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_gnt0, r_gnt1, r_gnt_t, r_start;
    logic               r_done0, r_done1, r_done_t;
    logic [2*WIDTH-1:0] r_result, r_result_t;
    logic [WIDTH-1:0]   r_a, r_a_t, r_b, r_b_t;
    logic               r_win, r_arb_t, r_lp, r_lp_t, r_mdone_q;

    logic               w_any, w_pick, w_arb_t, w_rise;
    logic               w_gnt0_nxt, w_gnt1_nxt, w_gnt_t_nxt, w_start_nxt;
    logic               w_done0_nxt, w_done1_nxt, w_done_t_nxt;

    assign w_any   = req0 | req1;
    // On a tie the requester that was not served last wins.
    assign w_pick  = (req0 & req1) ? ~r_lp : req1;
    assign w_arb_t = req0_t | req1_t | r_lp_t;
    // A done level left high from an earlier operation must not complete this one.
    assign w_rise  = mul_done & ~r_mdone_q;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_state_nxt = S_START;
            S_START: w_state_nxt = S_BUSY;
            S_BUSY:  if (w_rise) w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_gnt0_nxt   = 1'b0;
        w_gnt1_nxt   = 1'b0;
        w_gnt_t_nxt  = 1'b0;
        w_start_nxt  = 1'b0;
        w_done0_nxt  = 1'b0;
        w_done1_nxt  = 1'b0;
        w_done_t_nxt = 1'b0;
        case (r_state)
            S_IDLE: if (w_any) begin
                w_gnt0_nxt  = ~w_pick;
                w_gnt1_nxt  = w_pick;
                w_gnt_t_nxt = w_arb_t;
                w_start_nxt = 1'b1;
            end
            S_BUSY: if (w_rise) begin
                w_done0_nxt  = ~r_win;
                w_done1_nxt  = r_win;
                w_done_t_nxt = r_arb_t | mul_done_t;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
            r_gnt_t  <= 1'b0;
            r_start  <= 1'b0;
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
            r_done_t <= 1'b0;
        end else begin
            r_gnt0   <= w_gnt0_nxt;
            r_gnt1   <= w_gnt1_nxt;
            r_gnt_t  <= w_gnt_t_nxt;
            r_start  <= w_start_nxt;
            r_done0  <= w_done0_nxt;
            r_done1  <= w_done1_nxt;
            r_done_t <= w_done_t_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_win      <= 1'b0;
            r_arb_t    <= 1'b0;
            r_lp       <= 1'b1;
            r_lp_t     <= 1'b0;
            r_mdone_q  <= 1'b0;
            r_a        <= '0;
            r_a_t      <= '0;
            r_b        <= '0;
            r_b_t      <= '0;
            r_result   <= '0;
            r_result_t <= '0;
        end else begin
            r_mdone_q <= mul_done;
            if (r_state == S_IDLE && w_any) begin
                r_win   <= w_pick;
                r_arb_t <= w_arb_t;
                r_a     <= w_pick ? a1   : a0;
                r_a_t   <= w_pick ? a1_t : a0_t;
                r_b     <= w_pick ? b1   : b0;
                r_b_t   <= w_pick ? b1_t : b0_t;
            end
            if (r_state == S_BUSY && w_rise) begin
                r_result   <= mul_product;
                r_result_t <= mul_product_t;
            end
            if (r_state == S_RESP) begin
                r_lp   <= r_win;
                r_lp_t <= r_arb_t;
            end
        end
    end

    assign gnt0               = r_gnt0;
    assign gnt1               = r_gnt1;
    assign gnt0_t             = r_gnt_t;
    assign gnt1_t             = r_gnt_t;
    assign mul_start          = r_start;
    assign mul_start_t        = r_gnt_t;
    assign done0              = r_done0;
    assign done1              = r_done1;
    assign done0_t            = r_done_t;
    assign done1_t            = r_done_t;
    assign result             = r_result;
    assign result_t           = r_result_t;
    assign mul_multiplier     = r_a;
    assign mul_multiplier_t   = r_a_t;
    assign mul_multiplicand   = r_b;
    assign mul_multiplicand_t = r_b_t;

endmodule

// File: tb/tb_mult_arbiter_tainttrack.sv
// Scoreboarded random bench for mult_arbiter_tainttrack: a queue-based arbitration model predicts grants and
// completions, a responder plays the shared multiplier, and a monitor compares whatever the DUT presents.
module tb_mult_arbiter_tainttrack;
    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic req0, req0_t, req1, req1_t;
    logic [W-1:0] a0, a0_t, b0, b0_t, a1, a1_t, b1, b1_t;
    logic gnt0, gnt0_t, gnt1, gnt1_t, done0, done0_t, done1, done1_t;
    logic [2*W-1:0] result, result_t;
    logic mul_start, mul_start_t;
    logic [W-1:0] mul_multiplier, mul_multiplier_t, mul_multiplicand, mul_multiplicand_t;
    logic [2*W-1:0] mul_product, mul_product_t;
    logic mul_done, mul_done_t;

    mult_arbiter_tainttrack #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req0_t(req0_t), .req1(req1), .req1_t(req1_t),
        .a0(a0), .a0_t(a0_t), .b0(b0), .b0_t(b0_t),
        .a1(a1), .a1_t(a1_t), .b1(b1), .b1_t(b1_t),
        .gnt0(gnt0), .gnt0_t(gnt0_t), .gnt1(gnt1), .gnt1_t(gnt1_t),
        .done0(done0), .done0_t(done0_t), .done1(done1), .done1_t(done1_t),
        .result(result), .result_t(result_t),
        .mul_start(mul_start), .mul_start_t(mul_start_t),
        .mul_multiplier(mul_multiplier), .mul_multiplier_t(mul_multiplier_t),
        .mul_multiplicand(mul_multiplicand), .mul_multiplicand_t(mul_multiplicand_t),
        .mul_product(mul_product), .mul_product_t(mul_product_t),
        .mul_done(mul_done), .mul_done_t(mul_done_t)
    );

    typedef struct {
        logic win; logic [W-1:0] a, b, a_t, b_t; logic arb_t; int cyc;
    } gnt_exp_t;
    typedef struct {
        logic win; logic [2*W-1:0] prod, prod_t; logic done_t;
    } done_exp_t;
    typedef struct {
        int hold; int low; logic [2*W-1:0] prod, prod_t; logic done_t;
    } plan_t;

    gnt_exp_t  gq[$];
    done_exp_t dq[$];
    plan_t     pq[$];
    int        rise_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference state: pending requests, last-served pointer and its taint, first cycle the arbiter is idle.
    bit   pend[2];
    int   drv[2];
    logic lp_m, lp_t_m;
    int   idle_from;
    logic [2*W-1:0] last_res;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: event did not occur within its bound (cycle %0d)", nm, cyc);
    endtask

    // Monitor: compares every grant and completion against the head of the expectation queues.
    gnt_exp_t  mg;
    done_exp_t md;
    int        mr;
    always @(negedge clk) begin
        if (!rst) begin
            if (gnt0 | gnt1 | mul_start) begin
                chk("gnt_onehot", 64'(gnt0 & gnt1), 64'd0);
                chk("start_with_gnt", 64'(mul_start), 64'(gnt0 | gnt1));
                if (gq.size() == 0) begin
                    chk("unexpected_gnt", 64'({gnt1, gnt0}), 64'd0);
                end else begin
                    mg = gq.pop_front();
                    chk("gnt_who", 64'({gnt1, gnt0}), mg.win ? 64'd2 : 64'd1);
                    chk("gnt_cycle", 64'(cyc), 64'(mg.cyc));
                    chk("gnt0_t", 64'(gnt0_t), 64'(mg.arb_t));
                    chk("gnt1_t", 64'(gnt1_t), 64'(mg.arb_t));
                    chk("mul_start_t", 64'(mul_start_t), 64'(mg.arb_t));
                    chk("multiplier", 64'(mul_multiplier), 64'(mg.a));
                    chk("multiplier_t", 64'(mul_multiplier_t), 64'(mg.a_t));
                    chk("multiplicand", 64'(mul_multiplicand), 64'(mg.b));
                    chk("multiplicand_t", 64'(mul_multiplicand_t), 64'(mg.b_t));
                    chk("result_hold", result, last_res);
                end
            end
            if (done0 | done1) begin
                chk("done_onehot", 64'(done0 & done1), 64'd0);
                if (dq.size() == 0) begin
                    chk("unexpected_done", 64'({done1, done0}), 64'd0);
                end else begin
                    md = dq.pop_front();
                    chk("done_who", 64'({done1, done0}), md.win ? 64'd2 : 64'd1);
                    chk("done0_t", 64'(done0_t), 64'(md.done_t));
                    chk("done1_t", 64'(done1_t), 64'(md.done_t));
                    chk("result", result, md.prod);
                    chk("result_t", result_t, md.prod_t);
                    last_res = md.prod;
                end
                if (rise_q.size() == 0) begin
                    fail("done_without_mul_edge");
                end else begin
                    mr = rise_q.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(mr + 1));
                end
            end
        end
    end

    // Multiplier responder: keeps any stale done level, drops it, then raises it with the planned product.
    initial begin
        plan_t p;
        bit    ab;
        int    k;
        mul_done = 1'b0; mul_done_t = 1'b0; mul_product = '0; mul_product_t = '0;
        forever begin
            @(negedge clk);
            if (!rst && mul_start) begin
                if (pq.size() == 0) begin
                    fail("plan_underflow");
                end else begin
                    p = pq.pop_front();
                    ab = 1'b0;
                    k = 0;
                    while (!ab && k <= p.hold + p.low) begin
                        @(posedge clk); #2;
                        if (rst) begin
                            ab = 1'b1;
                        end else if (k < p.hold + p.low) begin
                            if (k >= p.hold) mul_done = 1'b0;
                            mul_product   = {$urandom, $urandom};
                            mul_product_t = {$urandom, $urandom};
                            mul_done_t    = 1'($urandom_range(0, 1));
                        end else begin
                            mul_done      = 1'b1;
                            mul_product   = p.prod;
                            mul_product_t = p.prod_t;
                            mul_done_t    = p.done_t;
                            rise_q.push_back(cyc);
                        end
                        k++;
                    end
                    if (!ab) begin
                        @(posedge clk); #2;
                        mul_product   = {$urandom, $urandom};
                        mul_product_t = {$urandom, $urandom};
                        mul_done_t    = 1'($urandom_range(0, 1));
                    end
                end
            end
        end
    end

    task automatic raise(input int n, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] at, input logic [W-1:0] bt);
        if (n == 0) begin a0 = a; b0 = b; a0_t = at; b0_t = bt; req0 = 1'b1; end
        else        begin a1 = a; b1 = b; a1_t = at; b1_t = bt; req1 = 1'b1; end
        pend[n] = 1'b1;
        drv[n]  = cyc;
    endtask

    task automatic raise_rand(input int n);
        raise(n, $urandom, $urandom,
              ($urandom_range(0, 3) == 0) ? $urandom : 32'd0,
              ($urandom_range(0, 3) == 0) ? $urandom : 32'd0);
    endtask

    // Decide the next winner from the pending set, queue expectations, then follow the operation.
    // mid: 0 never, 1 sometimes, 2 always raise the other requester while the multiplier is busy.
    task automatic serve(input bit clean, input int hold, input int mid, input bit stop);
        gnt_exp_t  g;
        done_exp_t d;
        plan_t     p;
        logic      w;
        int        t, first, oth;
        logic [2*W-1:0] ea, eb;
        w = (pend[0] && pend[1]) ? ~lp_m : logic'(pend[1]);
        g.win = w;
        g.a   = w ? a1 : a0;
        g.b   = w ? b1 : b0;
        g.a_t = w ? a1_t : a0_t;
        g.b_t = w ? b1_t : b0_t;
        g.arb_t = req0_t | req1_t | lp_t_m;
        first = (pend[0] && pend[1]) ? ((drv[0] < drv[1]) ? drv[0] : drv[1]) : drv[w];
        g.cyc = ((first > idle_from) ? first : idle_from) + 1;
        ea = {{W{1'b0}}, g.a};
        eb = {{W{1'b0}}, g.b};
        p.hold   = (hold < 0) ? int'($urandom_range(0, 3)) : hold;
        p.low    = int'($urandom_range(1, 3));
        p.prod   = ea * eb;
        p.prod_t = clean ? '0 : {$urandom, $urandom};
        p.done_t = clean ? 1'b0 : 1'($urandom_range(0, 1));
        d.win = w; d.prod = p.prod; d.prod_t = p.prod_t; d.done_t = g.arb_t | p.done_t;
        gq.push_back(g); dq.push_back(d); pq.push_back(p);

        t = 0;
        do begin @(negedge clk); t++; end while (((w ? gnt1 : gnt0) !== 1'b1) && t < 20);
        if ((w ? gnt1 : gnt0) !== 1'b1) fail("gnt_timeout");
        @(posedge clk); #1;
        if (w) req1 = 1'b0; else req0 = 1'b0;
        pend[w] = 1'b0;
        if (stop) return;
        oth = w ? 0 : 1;
        if (!pend[oth] && (mid == 2 || (mid == 1 && $urandom_range(0, 2) == 0))) begin
            @(posedge clk); #1;
            raise_rand(oth);
        end
        t = 0;
        do begin @(negedge clk); t++; end while (!(done0 | done1) && t < 40);
        if (!(done0 | done1)) begin
            fail("done_timeout");
        end else begin
            lp_m = w;
            lp_t_m = g.arb_t;
            idle_from = cyc + 1;
        end
        @(posedge clk); #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_gnt"}, 64'({gnt0, gnt1, gnt0_t, gnt1_t}), 64'd0);
        chk({tag, "_done"}, 64'({done0, done1, done0_t, done1_t}), 64'd0);
        chk({tag, "_start"}, 64'({mul_start, mul_start_t}), 64'd0);
        chk({tag, "_result"}, result, 64'd0);
        chk({tag, "_result_t"}, result_t, 64'd0);
        chk({tag, "_mplier"}, {mul_multiplier, mul_multiplier_t}, 64'd0);
        chk({tag, "_mcand"}, {mul_multiplicand, mul_multiplicand_t}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req0 = 1'b0; req0_t = 1'b0; req1 = 1'b0; req1_t = 1'b0;
        a0 = '0; a0_t = '0; b0 = '0; b0_t = '0; a1 = '0; a1_t = '0; b1 = '0; b1_t = '0;
        pend[0] = 1'b0; pend[1] = 1'b0; drv[0] = 0; drv[1] = 0;
        lp_m = 1'b1; lp_t_m = 1'b0; last_res = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        idle_from = cyc;

        // Ties from reset: 0, then 1 (the loser), then 0 again.
        raise_rand(0); raise_rand(1);
        serve(1'b0, -1, 0, 1'b0);
        raise_rand(0);
        serve(1'b0, -1, 0, 1'b0);
        serve(1'b0, -1, 0, 1'b0);

        // Plain 3*5 with no taint and a stale done level held for two cycles.
        req0_t = 1'b0; req1_t = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        raise(0, 32'd3, 32'd5, 32'd0, 32'd0);
        serve(1'b1, 2, 0, 1'b0);

        // Taint from an idle requester's req_t and from operand b1_t.
        req0_t = 1'b1;
        raise(1, $urandom, $urandom, 32'd0, 32'd1);
        serve(1'b0, -1, 0, 1'b0);
        req0_t = 1'b0;

        // Request arriving during BUSY must wait for IDLE.
        raise_rand(0);
        serve(1'b0, -1, 2, 1'b0);
        while (pend[0] || pend[1]) serve(1'b0, -1, 0, 1'b0);

        repeat (60) begin
            req0_t = ($urandom_range(0, 3) == 0);
            req1_t = ($urandom_range(0, 3) == 0);
            if (!pend[0] && $urandom_range(0, 1) == 1) raise_rand(0);
            if (!pend[1] && $urandom_range(0, 1) == 1) raise_rand(1);
            if (!pend[0] && !pend[1]) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                raise_rand(int'($urandom_range(0, 1)));
            end
            serve(1'b0, -1, 1, 1'b0);
        end
        while (pend[0] || pend[1]) serve(1'b0, -1, 0, 1'b0);

        // Reset in the middle of BUSY abandons the operation.
        req0_t = 1'b0; req1_t = 1'b0;
        raise_rand(0);
        serve(1'b0, 10, 0, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        dq.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        lp_m = 1'b1; lp_t_m = 1'b0; last_res = '0;
        idle_from = cyc;
        @(negedge clk);
        check_all_zero("midrst");
        repeat (12) begin @(posedge clk); #1; end
        raise_rand(0); raise_rand(1);
        serve(1'b0, -1, 0, 1'b0);
        while (pend[0] || pend[1]) serve(1'b0, -1, 0, 1'b0);

        repeat (4) @(posedge clk);
        chk("gnt_queue_left", 64'(gq.size()), 64'd0);
        chk("done_queue_left", 64'(dq.size()), 64'd0);
        chk("plan_queue_left", 64'(pq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
